// File: rtl/idex_stage.sv
// Decode->execute pipeline stage: two-entry FIFO (head + skid) with valid/ready handshake,
// steering of the head to one of NUM_UNITS execute units, and CDB operand wakeup.
module idex_stage #(
   parameter int unsigned NUM_UNITS = 4,
   parameter int unsigned UNIT_W    = 2,
   parameter int unsigned OP_W      = 6,
   parameter int unsigned TAG_W     = 4,
   parameter int unsigned VAL_W     = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [UNIT_W-1:0]    in_unit,
   input  logic [OP_W-1:0]      in_op,
   input  logic [TAG_W-1:0]     in_tag1,
   input  logic [TAG_W-1:0]     in_tag2,
   input  logic [VAL_W-1:0]     in_val1,
   input  logic [VAL_W-1:0]     in_val2,
   input  logic [TAG_W-1:0]     in_target,
   input  logic                 cdb_valid,
   input  logic [TAG_W-1:0]     cdb_tag,
   input  logic [VAL_W-1:0]     cdb_val,
   output logic [NUM_UNITS-1:0] out_valid,
   input  logic [NUM_UNITS-1:0] out_ready,
   output logic [OP_W-1:0]      out_op,
   output logic [TAG_W-1:0]     out_tag1,
   output logic [TAG_W-1:0]     out_tag2,
   output logic [VAL_W-1:0]     out_val1,
   output logic [VAL_W-1:0]     out_val2,
   output logic [TAG_W-1:0]     out_target,
   output logic                 err_unit
);

   typedef struct packed {
      logic [UNIT_W-1:0] unit;
      logic [OP_W-1:0]   op;
      logic [TAG_W-1:0]  tag1;
      logic [VAL_W-1:0]  val1;
      logic [TAG_W-1:0]  tag2;
      logic [VAL_W-1:0]  val2;
      logic [TAG_W-1:0]  target;
   } entry_t;

   typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_t;

   localparam logic [UNIT_W:0] NumUnitsW = (UNIT_W + 1)'(NUM_UNITS);

   state_t state_q;
   entry_t head_q, skid_q;
   logic   err_q;

   entry_t in_entry, in_snoop, head_snoop, skid_snoop;
   logic   legal, accept, store, fire;

   // Tag 0 means the value is already present, so it never matches a broadcast.
   function automatic entry_t snoop(input entry_t e, input logic cv,
                                    input logic [TAG_W-1:0] ct, input logic [VAL_W-1:0] cval);
      entry_t r;
      r = e;
      if (cv && (e.tag1 != '0) && (e.tag1 == ct)) begin
         r.tag1 = '0;
         r.val1 = cval;
      end
      if (cv && (e.tag2 != '0) && (e.tag2 == ct)) begin
         r.tag2 = '0;
         r.val2 = cval;
      end
      return r;
   endfunction

   assign in_entry = '{unit: in_unit, op: in_op, tag1: in_tag1, val1: in_val1,
                       tag2: in_tag2, val2: in_val2, target: in_target};

   assign in_snoop   = snoop(in_entry, cdb_valid, cdb_tag, cdb_val);
   assign head_snoop = snoop(head_q, cdb_valid, cdb_tag, cdb_val);
   assign skid_snoop = snoop(skid_q, cdb_valid, cdb_tag, cdb_val);

   assign in_ready = (state_q != StTwo);
   assign legal    = ({1'b0, in_unit} < NumUnitsW);
   assign accept   = in_valid & in_ready;
   assign store    = accept & legal;
   assign fire     = |(out_valid & out_ready);

   always_comb begin
      out_valid = '0;
      for (int i = 0; i < int'(NUM_UNITS); i++) begin
         out_valid[i] = (state_q != StEmpty) && (head_q.unit == UNIT_W'(i));
      end
   end

   assign out_op     = head_q.op;
   assign out_tag1   = head_q.tag1;
   assign out_tag2   = head_q.tag2;
   assign out_val1   = head_q.val1;
   assign out_val2   = head_q.val2;
   assign out_target = head_q.target;
   assign err_unit   = err_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= StEmpty;
         head_q  <= '0;
         skid_q  <= '0;
         err_q   <= 1'b0;
      end else if (flush) begin
         state_q <= StEmpty;
         err_q   <= 1'b0;
      end else begin
         err_q  <= accept & ~legal;
         head_q <= head_snoop;
         skid_q <= skid_snoop;
         case (state_q)
            StEmpty: begin
               if (store) begin
                  head_q  <= in_snoop;
                  state_q <= StOne;
               end
            end
            StOne: begin
               if (fire && store) begin
                  head_q <= in_snoop;
               end else if (fire) begin
                  state_q <= StEmpty;
               end else if (store) begin
                  skid_q  <= in_snoop;
                  state_q <= StTwo;
               end
            end
            StTwo: begin
               if (fire) begin
                  head_q  <= skid_snoop;
                  state_q <= StOne;
               end
            end
            default: state_q <= StEmpty;
         endcase
      end
   end

endmodule
